// File: rtl/legv8_pkg.sv
// LEGv8 instruction field positions, branch opcodes and the fetch-queue entry
// type, shared between the fetch and issue logic.
package legv8_pkg;

  localparam int RD_LSB = 0;
  localparam int RN_LSB = 5;
  localparam int RM_LSB = 16;

  localparam logic [4:0] XZR = 5'd31;

  localparam logic [5:0]  OP_B        = 6'b000101;
  localparam logic [5:0]  OP_BL       = 6'b100101;
  localparam logic [6:0]  OP_CBZ_CBNZ = 7'b1011010;
  localparam logic [7:0]  OP_BCOND    = 8'b01010100;
  localparam logic [21:0] OP_BR       = 22'b1101011000011111000000;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/pair_hazard_check.sv
// Conservative pairing check: slot 2 may issue with slot 1 only when slot 1
// is not a branch and does not write a register slot 2 touches.
module pair_hazard_check
  import legv8_pkg::*;
(
  input  logic [31:0] inst1,
  input  logic [31:0] inst2,
  output logic        hazard
);

  logic [4:0] rd1, rd2, rn2, rm2;
  logic       is_br;
  logic       dep;

  assign rd1 = inst1[RD_LSB +: 5];
  assign rd2 = inst2[RD_LSB +: 5];
  assign rn2 = inst2[RN_LSB +: 5];
  assign rm2 = inst2[RM_LSB +: 5];

  assign is_br = (inst1[31:26] == OP_B)
              || (inst1[31:26] == OP_BL)
              || (inst1[31:25] == OP_CBZ_CBNZ)
              || (inst1[31:24] == OP_BCOND)
              || (inst1[31:10] == OP_BR);

  // Writes to XZR are discarded, so they never create a dependency.
  assign dep = (rd1 != XZR)
            && ((rd1 == rn2) || (rd1 == rm2) || (rd1 == rd2));

  assign hazard = is_br || dep;

endmodule

// File: rtl/dual_fetch_queue.sv
// Fetch stage: owns the fetch PC, captures two instructions per cycle into a
// circular queue and presents up to two of them per cycle to decode.
module dual_fetch_queue
  import legv8_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  output logic [63:0]                PC1,
  input  logic [31:0]                IC1,
  input  logic [31:0]                IC2,
  input  logic                       redirect,
  input  logic [63:0]                redirect_target,
  input  logic                       decode_ready,
  output logic                       issue_valid1,
  output logic [31:0]                issue_inst1,
  output logic [63:0]                issue_pc1,
  output logic                       issue_valid2,
  output logic [31:0]                issue_inst2,
  output logic [63:0]                issue_pc2,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [63:0]   pc_q, pc_d;
  fq_entry_t     mem_q [DEPTH];

  logic [PW-1:0] count;
  logic [AW-1:0] hd_idx, nx_idx;
  logic [AW-1:0] w0_idx, w1_idx;
  fq_entry_t     head, next;
  logic          has1, has2;
  logic          hazard;
  logic          push;
  logic [1:0]    n_pop;

  assign count  = wr_q - rd_q;
  assign hd_idx = rd_q[AW-1:0];
  assign nx_idx = hd_idx + 1'b1;
  assign w0_idx = wr_q[AW-1:0];
  assign w1_idx = w0_idx + 1'b1;
  assign head   = mem_q[hd_idx];
  assign next   = mem_q[nx_idx];
  assign has1   = (count != '0);
  assign has2   = (count >= PW'(2));

  pair_hazard_check u_hz (
    .inst1  (head.inst),
    .inst2  (next.inst),
    .hazard (hazard)
  );

  assign issue_valid1 = has1 && !redirect;
  assign issue_valid2 = has2 && !redirect && !hazard;
  assign issue_inst1  = has1 ? head.inst : '0;
  assign issue_pc1    = has1 ? head.pc   : '0;
  assign issue_inst2  = has2 ? next.inst : '0;
  assign issue_pc2    = has2 ? next.pc   : '0;
  assign queue_count  = count;
  assign PC1          = pc_q;

  // Room is judged on occupancy before this cycle's pops.
  assign push  = !redirect && (count <= PW'(DEPTH - 2));
  assign n_pop = decode_ready
               ? ({1'b0, issue_valid1} + {1'b0, issue_valid2})
               : 2'd0;

  always_comb begin
    rd_d = rd_q + PW'(n_pop);
    wr_d = push ? wr_q + PW'(2) : wr_q;
    pc_d = push ? pc_q + 64'd8 : pc_q;
    if (redirect) begin
      rd_d = '0;
      wr_d = '0;
      pc_d = redirect_target;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      rd_q <= '0;
      wr_q <= '0;
      pc_q <= RESET_PC;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      pc_q <= pc_d;
      if (push) begin
        mem_q[w0_idx] <= '{inst: IC1, pc: pc_q};
        mem_q[w1_idx] <= '{inst: IC2, pc: pc_q + 64'd4};
      end
    end
  end

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed and randomized checks of dual_fetch_queue against a queue model.
module tb_dual_fetch_queue;

  localparam int          DEPTH    = 8;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic [63:0] PC1;
  logic [31:0] IC1 = '0, IC2 = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = '0;
  logic        decode_ready = 1'b0;
  logic        issue_valid1, issue_valid2;
  logic [31:0] issue_inst1, issue_inst2;
  logic [63:0] issue_pc1, issue_pc2;
  logic [3:0]  queue_count;

  dual_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .PC1(PC1), .IC1(IC1), .IC2(IC2),
    .redirect(redirect), .redirect_target(redirect_target),
    .decode_ready(decode_ready),
    .issue_valid1(issue_valid1), .issue_inst1(issue_inst1),
    .issue_pc1(issue_pc1),
    .issue_valid2(issue_valid2), .issue_inst2(issue_inst2),
    .issue_pc2(issue_pc2), .queue_count(queue_count)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ment_t;

  ment_t       mq[$];
  logic [63:0] mpc;
  bit          armed = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Branch or register-dependency rule for pairing two instructions.
  function automatic bit ref_hazard(input logic [31:0] a,
                                    input logic [31:0] b);
    bit br;
    int wr_reg;
    br = (a[31:26] == 6'h05) || (a[31:26] == 6'h25)
      || (a[31:25] == 7'h5A) || (a[31:24] == 8'h54)
      || (a[31:10] == 22'h3587C0);
    wr_reg = int'(a[4:0]);
    if (br) return 1;
    if (wr_reg == 31) return 0;
    return (wr_reg == int'(b[9:5])) || (wr_reg == int'(b[20:16]))
        || (wr_reg == int'(b[4:0]));
  endfunction

  task automatic step(input logic rst, input logic redir,
                      input logic [63:0] tgt, input logic rdy,
                      input logic [31:0] i1, input logic [31:0] i2);
    bit ev1, ev2;
    int n, pops;
    @(negedge CLOCK);
    RESET = rst;
    redirect = redir;
    redirect_target = tgt;
    decode_ready = rdy;
    IC1 = i1;
    IC2 = i2;
    #1;
    n = mq.size();
    ev1 = (n >= 1) && !redir;
    ev2 = (n >= 2) && !redir && !ref_hazard(mq[0].inst, mq[1].inst);
    if (armed) begin
      chk("pc1_out", PC1, mpc);
      chk("count", 64'(queue_count), 64'(n));
      chk("valid1", 64'(issue_valid1), 64'(ev1));
      chk("valid2", 64'(issue_valid2), 64'(ev2));
      chk("inst1", 64'(issue_inst1), (n >= 1) ? 64'(mq[0].inst) : 64'h0);
      chk("ipc1", issue_pc1, (n >= 1) ? mq[0].pc : 64'h0);
      chk("inst2", 64'(issue_inst2), (n >= 2) ? 64'(mq[1].inst) : 64'h0);
      chk("ipc2", issue_pc2, (n >= 2) ? mq[1].pc : 64'h0);
    end
    @(posedge CLOCK);
    if (!rst) begin
      mq.delete();
      mpc = RESET_PC;
      armed = 1;
    end else if (redir) begin
      mq.delete();
      mpc = tgt;
    end else begin
      pops = rdy ? (int'(ev1) + int'(ev2)) : 0;
      for (int k = 0; k < pops; k++) void'(mq.pop_front());
      if (DEPTH - n >= 2) begin
        mq.push_back('{inst: i1, pc: mpc});
        mq.push_back('{inst: i2, pc: mpc + 64'd4});
        mpc = mpc + 64'd8;
      end
    end
  endtask

  function automatic logic [31:0] add_inst(input int d, input int n,
                                           input int m);
    return 32'h8B000000 | (32'(m) << 16) | (32'(n) << 5) | 32'(d);
  endfunction

  function automatic logic [31:0] rnd_inst();
    int r;
    int regs[4] = '{0, 1, 2, 31};
    r = $urandom_range(0, 11);
    case (r)
      0: return 32'h14000000 | ($urandom & 32'h03FFFFFF);
      1: return 32'h94000000 | ($urandom & 32'h03FFFFFF);
      2: return 32'hB4000000 | ($urandom & 32'h01FFFFFF);
      3: return 32'h54000000 | ($urandom & 32'h00FFFFFF);
      4: return 32'hD61F0000 | (32'($urandom_range(0, 31)) << 5);
      default: return add_inst(regs[$urandom_range(0, 3)],
                               regs[$urandom_range(0, 3)],
                               regs[$urandom_range(0, 3)]);
    endcase
  endfunction

  localparam logic [31:0] IA = 32'h8B020020;
  localparam logic [31:0] IB = 32'h8B040062;

  initial begin
    // Reset, then first dual push from RESET_PC.
    step(0, 0, 0, 0, IA, IB);
    step(0, 0, 0, 0, IA, IB);
    #1;
    chk("rst_pc", PC1, 64'h0);
    chk("rst_cnt", 64'(queue_count), 64'h0);
    chk("rst_v1", 64'(issue_valid1), 64'h0);
    chk("rst_inst1", 64'(issue_inst1), 64'h0);
    step(1, 0, 0, 1, IA, IB);
    #1;
    chk("first_pc", PC1, 64'h8);
    chk("first_v2", 64'(issue_valid2), 64'h1);
    chk("first_ipc2", issue_pc2, 64'h4);

    // Dependent pair: second ADD moves up to slot 1.
    step(0, 0, 0, 0, IA, IB);
    step(1, 0, 0, 0, add_inst(1, 1, 2), add_inst(3, 1, 4));
    #1;
    chk("dep_v2", 64'(issue_valid2), 64'h0);
    chk("dep_ipc1", issue_pc1, 64'h0);
    step(1, 0, 0, 1, IA, IB);
    #1;
    chk("dep_next_pc", issue_pc1, 64'h4);
    chk("dep_next_inst", 64'(issue_inst1), 64'(add_inst(3, 1, 4)));

    // Branch in slot 1, then XZR destination.
    step(0, 0, 0, 0, IA, IB);
    step(1, 0, 0, 1, 32'h14000004, IA);
    #1;
    chk("br_v2", 64'(issue_valid2), 64'h0);
    step(0, 0, 0, 0, IA, IB);
    step(1, 0, 0, 1, add_inst(31, 1, 2), add_inst(3, 31, 4));
    #1;
    chk("xzr_v2", 64'(issue_valid2), 64'h1);

    // Fill to full, then drain.
    step(0, 0, 0, 0, IA, IB);
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, IA, IB);
    #1;
    chk("full_cnt", 64'(queue_count), 64'h8);
    chk("full_pc", PC1, 64'h20);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1, IA, IB);

    // Redirect with 6 queued.
    step(0, 0, 0, 0, IA, IB);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, IA, IB);
    step(1, 1, 64'h100, 1, IA, IB);
    #1;
    chk("redir_cnt", 64'(queue_count), 64'h0);
    chk("redir_pc", PC1, 64'h100);
    step(1, 0, 0, 1, IA, IB);
    #1;
    chk("redir_ipc1", issue_pc1, 64'h100);
    chk("redir_ipc2", issue_pc2, 64'h104);

    // Reset mid-fill.
    for (int k = 0; k < 2; k++) step(1, 0, 0, 0, IA, IB);
    step(0, 0, 0, 0, IA, IB);
    #1;
    chk("mrst_cnt", 64'(queue_count), 64'h0);
    chk("mrst_pc", PC1, RESET_PC);
    chk("mrst_pc2", issue_pc2, 64'h0);

    // Randomized traffic, including redirects near the top of the PC space.
    for (int k = 0; k < 600; k++) begin
      logic        rs, rd;
      logic [63:0] tg;
      rs = ($urandom_range(0, 59) != 0);
      rd = ($urandom_range(0, 19) == 0);
      tg = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 2) == 0) tg = 64'hFFFF_FFFF_FFFF_FFF0;
      step(rs, rd, tg, logic'($urandom_range(0, 9) < 7),
           rnd_inst(), rnd_inst());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_fetch_queue.md
Name: dual_fetch_queue

Overview:
- Front-end stage between the instruction cache and the dual-issue decode of the superscalar LEGv8 core.
- Owns the fetch PC and drives it to the cache.
- Each cycle, captures the two instructions the cache returns combinationally for PC and PC+4 into a circular queue.
- Presents up to two instructions per cycle to decode. A pairing check sends the second slot only when it is independent of the first.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 4.
- RESET_PC, 64'h0, fetch PC after reset.

Ports:
- CLOCK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on the CLOCK rising edge, asserted when 0.
- PC1  out  64  fetch address to the instruction cache (second instruction is at PC1+4).
- IC1  in  32  instruction at PC1, valid in the same cycle.
- IC2  in  32  instruction at PC1+4, valid in the same cycle.
- redirect  in  1  taken branch or flush request from execute.
- redirect_target  in  64  new fetch PC; bits [1:0] are 0.
- decode_ready  in  1  decode accepts whatever is valid this cycle.
- issue_valid1  out  1  slot 1 valid.
- issue_inst1  out  32  slot 1 instruction.
- issue_pc1  out  64  slot 1 PC.
- issue_valid2  out  1  slot 2 valid.
- issue_inst2  out  32  slot 2 instruction.
- issue_pc2  out  64  slot 2 PC.
- queue_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Each entry holds {inst[31:0], pc[63:0]}.
  - Read and write pointers are $clog2(DEPTH)+1 bits; the extra bit is the wrap flag.
  - count = wr - rd, computed modulo.
- Reset (RESET==0 at an edge):
  - PC1 = RESET_PC; rd = wr = 0; queue_count = 0.
  - All issue outputs are 0; issue_* outputs are combinational from the registered state, so they read 0 when the queue is empty.
  - Reset mid-operation discards all queued entries; the cycle after reset, the queue pushes from RESET_PC.
- Push:
  - Condition: !redirect and (DEPTH - count_before_pop) >= 2.
  - Writes IC1/PC1 to entry wr and IC2/PC1+4 to entry wr+1.
  - wr += 2; PC1 += 8.
  - If the condition fails, PC1 holds and the cache output is ignored.
  - Never a single-entry push.
- Issue slot 1: issue_valid1 = (count >= 1) and !redirect; carries the head entry.
- Issue slot 2: issue_valid2 = (count >= 2) and !redirect and !hazard; carries head+1.
- Hazard, combinational and conservative. Fields: Rd = [4:0], Rn = [9:5], Rm = [20:16]. hazard = 1 if either of:
  - slot 1 is a branch: B [31:26]=000101, BL [31:26]=100101, CBZ/CBNZ [31:25]=1011010, B.cond [31:24]=01010100, BR [31:10]=1101011000011111000000.
  - slot 1 Rd != 31 and slot 1 Rd equals any of slot 2's Rn, Rm or Rd.
- Pop:
  - On decode_ready, rd advances by issue_valid1 + issue_valid2 (0, 1 or 2).
  - Push and pop in the same cycle are both applied; count is updated by +2 and minus the pops.
- Redirect (highest priority):
  - Next state: rd = wr = 0 and PC1 = redirect_target.
  - No push or pop occurs in that cycle; issue valids are forced to 0.
  - The first push from the target happens the next cycle.
- Latency: an instruction fetched at edge N can issue in the cycle after edge N (one-cycle fetch-to-issue).
- PC arithmetic is 64-bit and wraps modulo 2^64.
- Full queue: no overflow by construction. Empty queue: no valid issue.
- No bubble when dual-issue is blocked: slot 2's instruction becomes slot 1 in the following cycle.

Decomposition:
- Shared package legv8_pkg holds:
  - instruction field bit positions (RD_LSB, RN_LSB, RM_LSB);
  - XZR = 5'd31;
  - branch opcode constants (OP_B, OP_BL, OP_CBZ_CBNZ, OP_BCOND, OP_BR);
  - a typedef fq_entry_t {inst, pc}.
- One sub-module: pair_hazard_check. It is purely combinational: inputs inst1 and inst2, output hazard. It is reused later by the issue logic.

Test Plan:
- Reset with RESET=0 for 2 cycles, then release; cache returns 32'h8B020020 / 32'h8B040062 -> PC1 is 0, then 8; the next cycle issue_valid1=issue_valid2=1 with pc1=0, pc2=4.
- Dependent pair: ADD X1,X1,X2 followed by ADD X3,X1,X4 -> issue_valid2=0 and pc1=0 issues; the next cycle the second ADD issues in slot 1 with pc=4.
- Branch in slot 1 (inst1=32'h14000004, B) with decode_ready=1 -> issue_valid2=0; Rd=31 in slot 1 with Rn=31 in slot 2 -> no hazard, both issue.
- Fill: decode_ready=0 for 5 cycles with DEPTH=8 -> queue_count goes 2,4,6,8,8, and PC1 stops at 32 after reaching 8 entries; ready=1 then drains 2 per cycle.
- Redirect to 64'h100 while count=6 and decode_ready=1 -> both valids are 0 that cycle, then count=0 and PC1=0x100; the following cycle issues pc1=0x100, pc2=0x104.
- RESET=0 asserted mid-fill (count=6) -> the next cycle count=0, PC1=RESET_PC, all issue outputs 0.
